// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: button-request FSM plus MM:SS BCD up/down counter.
// Every output is registered and derived from the next-state values.
module stopwatch_ctrl #(
  parameter logic [3:0] MAX_MIN_TENS = 4'd5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        in1_pulse,
  input  logic        in2_pulse,
  input  logic        in2_long_pulse,
  input  logic        mode_pulse,
  output logic [15:0] disp,
  output logic [1:0]  state,
  output logic        running,
  output logic        dir,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_e;

  state_e      state_q, state_d, req_state_s;
  logic        dir_q, dir_d;
  logic [15:0] count_q, count_d;
  logic [15:0] lap_q, lap_d;
  logic [15:0] disp_q, disp_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic        counting_s;
  logic        zero_hit_s;
  logic [15:0] count_step_s;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd9) begin
      so = so + 4'd1;
    end else begin
      so = 4'd0;
      if (st != 4'd5) begin
        st = st + 4'd1;
      end else begin
        st = 4'd0;
        if (mo != 4'd9) begin
          mo = mo + 4'd1;
        end else begin
          mo = 4'd0;
          if (mt != MAX_MIN_TENS) mt = mt + 4'd1;
          else                    mt = 4'd0;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          if (mt != 4'd0) mt = mt - 4'd1;
          else            mt = MAX_MIN_TENS;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // Counting is decided on the current state, independent of this cycle's transition.
  assign counting_s   = tick && ((state_q == S_RUN) || (state_q == S_LAP)) && !in2_long_pulse;
  assign zero_hit_s   = counting_s && dir_q && (count_q == 16'h0001);
  assign count_step_s = dir_q ? bcd_dec(count_q) : bcd_inc(count_q);

  // Register process for all state and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      count_q   <= 16'h0000;
      lap_q     <= 16'h0000;
      disp_q    <= 16'h0000;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      count_q   <= count_d;
      lap_q     <= lap_d;
      disp_q    <= disp_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // Next-state: only the highest-priority request acts; lower ones are dropped.
  always_comb begin
    req_state_s = state_q;
    dir_d       = dir_q;
    lap_d       = lap_q;
    count_d     = count_q;
    state_d     = state_q;
    if (in2_long_pulse) begin
      state_d = S_IDLE;
      count_d = 16'h0000;
      lap_d   = 16'h0000;
    end else begin
      if (counting_s) count_d = count_step_s;
      else            count_d = count_q;
      case (state_q)
        S_IDLE: begin
          if (in1_pulse) begin
            if (!dir_q) req_state_s = S_RUN;
            else        req_state_s = S_IDLE;
          end else if (mode_pulse && !in2_pulse) begin
            dir_d = ~dir_q;
          end else begin
            req_state_s = S_IDLE;
          end
        end
        S_RUN: begin
          if (in1_pulse) begin
            req_state_s = S_PAUSE;
          end else if (in2_pulse) begin
            req_state_s = S_LAP;
            lap_d       = count_q;
          end else begin
            req_state_s = S_RUN;
          end
        end
        S_LAP: begin
          if (in1_pulse)      req_state_s = S_PAUSE;
          else if (in2_pulse) req_state_s = S_RUN;
          else                req_state_s = S_LAP;
        end
        S_PAUSE: begin
          if (in1_pulse) begin
            if (dir_q && (count_q == 16'h0000)) req_state_s = S_PAUSE;
            else                                req_state_s = S_RUN;
          end else if (mode_pulse && !in2_pulse) begin
            dir_d = ~dir_q;
          end else begin
            req_state_s = S_PAUSE;
          end
        end
        default: req_state_s = S_IDLE;
      endcase
      state_d = zero_hit_s ? S_PAUSE : req_state_s;
    end
  end

  // Output next-values, computed from next state so they land on the same edge.
  always_comb begin
    running_d = (state_d == S_RUN) || (state_d == S_LAP);
    disp_d    = (state_d == S_LAP) ? lap_d : count_d;
    done_d    = zero_hit_s;
  end

  assign disp    = disp_q;
  assign state   = state_q;
  assign running = running_q;
  assign dir     = dir_q;
  assign done    = done_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: driver queues expected outputs per cycle,
// a monitor pops and compares them at the falling edge of that cycle.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        in1_pulse = 1'b0;
  logic        in2_pulse = 1'b0;
  logic        in2_long_pulse = 1'b0;
  logic        mode_pulse = 1'b0;
  logic [15:0] disp;
  logic [1:0]  state;
  logic        running;
  logic        dir;
  logic        done;

  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] disp;
    logic [1:0]  st;
    logic        run;
    logic        dir;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_cnt = 0;

  stopwatch_ctrl #(.MAX_MIN_TENS(4'd5)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .in1_pulse(in1_pulse), .in2_pulse(in2_pulse),
    .in2_long_pulse(in2_long_pulse), .mode_pulse(mode_pulse),
    .disp(disp), .state(state), .running(running), .dir(dir), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Drive one cycle of inputs; returns just after the edge that samples them.
  task automatic step(input logic t, input logic i1, input logic i2,
                      input logic l, input logic m, input logic r);
    rst = r; tick = t; in1_pulse = i1; in2_pulse = i2;
    in2_long_pulse = l; mode_pulse = m;
    @(posedge clk);
    #1;
    rst = 1'b0; tick = 1'b0; in1_pulse = 1'b0; in2_pulse = 1'b0;
    in2_long_pulse = 1'b0; mode_pulse = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [15:0] d, input logic [1:0] s,
                            input logic ru, input logic di, input logic dn);
    exp_t e;
    e.cyc = cyc_cnt; e.name = nm; e.disp = d; e.st = s;
    e.run = ru; e.dir = di; e.done = dn;
    q.push_back(e);
  endtask

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        e = q.pop_front();
        total++;
        if (e.cyc != cyc_cnt ||
            {disp, state, running, dir, done} !== {e.disp, e.st, e.run, e.dir, e.done}) begin
          bad++;
          $display("FAIL %s: got disp=%h state=%0d running=%b dir=%b done=%b, want disp=%h state=%0d running=%b dir=%b done=%b",
                   e.name, disp, state, running, dir, done, e.disp, e.st, e.run, e.dir, e.done);
        end
      end
    end
  end

  initial begin
    // Reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("reset", 16'h0000, IDLE, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("idle_tick", 16'h0000, IDLE, 1'b0, 1'b0, 1'b0);

    // Start, 65 ticks with carry checks
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("start", 16'h0000, RUN, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 65; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 10) expect_out("carry_09_10", 16'h0010, RUN, 1'b1, 1'b0, 1'b0);
      if (i == 60) expect_out("carry_59_00", 16'h0100, RUN, 1'b1, 1'b0, 1'b0);
    end
    expect_out("run_0105", 16'h0105, RUN, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("pause", 16'h0105, PAUSE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("pause_hold", 16'h0105, PAUSE, 1'b0, 1'b0, 1'b0);

    // Lap
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("clear_pause", 16'h0000, IDLE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("run_0010", 16'h0010, RUN, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("lap_enter", 16'h0010, LAP, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("lap_frozen", 16'h0010, LAP, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("lap_exit", 16'h0015, RUN, 1'b1, 1'b0, 1'b0);

    // Full wrap 59:58 -> 00:00
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3598; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("run_5958", 16'h5958, RUN, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("run_5959", 16'h5959, RUN, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("wrap_0000", 16'h0000, RUN, 1'b1, 1'b0, 1'b0);

    // Down-count to zero
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("pause_0003", 16'h0003, PAUSE, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("mode_down", 16'h0003, PAUSE, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("run_down", 16'h0003, RUN, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("down_0002", 16'h0002, RUN, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("done_pulse", 16'h0000, PAUSE, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("done_clear", 16'h0000, PAUSE, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("start_ignored_zero", 16'h0000, PAUSE, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("clear_keeps_dir", 16'h0000, IDLE, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("idle_start_down_ign", 16'h0000, IDLE, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("idle_mode_up", 16'h0000, IDLE, 1'b0, 1'b0, 1'b0);

    // Clear priority at 02:30, mode ignored in RUN
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 150; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("run_0230", 16'h0230, RUN, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("mode_ign_run", 16'h0230, RUN, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("clear_wins", 16'h0000, IDLE, 1'b0, 1'b0, 1'b0);

    // Lap captures pre-tick count; reset during LAP with tick
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("lap_pretick", 16'h0002, LAP, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("lap_count_ran", 16'h0003, RUN, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("rst_in_lap", 16'h0000, IDLE, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
